mem_access_ctrl: RTL and testbench

//  MEM-stage load/store sequencer. Takes one decoded access per instruction, drives the data-bus
//  req/gnt/rvalid handshake, and holds the pipeline via stall_req (feeds the mem_stall network)

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_lsu_align.sv | 57 +++++
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage load/store path: exception codes
// returned to cpu_ctrl and the access-size codes carried by req_size.
package mem_access_ctrl_pkg;

    localparam int ISA_EXP_W = 4;

    localparam logic [ISA_EXP_W-1:0] ISA_EXP_NONE            = 4'd0;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_LD_MISALIGNED   = 4'd4;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_LD_ACCESS_FAULT = 4'd5;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_ST_MISALIGNED   = 4'd6;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_ST_ACCESS_FAULT = 4'd7;

    // Size code 2'b11 is not a legal encoding and is handled as a word.
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

endpackage

// File: rtl/mem_access_ctrl_lsu_align.sv
// Byte-lane steering for the load/store unit: alignment check, byte
// enables, store-data lane replication and load extraction/extension.
// Purely combinational so a store buffer can reuse it unchanged.
module mem_access_ctrl_lsu_align (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);
    import mem_access_ctrl_pkg::*;

    logic [31:0] lane;

    // Bring the addressed byte/half down to bit 0 before extension.
    assign lane = rdata >> {addr_lo, 3'b000};

    // Store side: alignment, byte enables and replicated write data.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata_rep  = wdata;
        case (size)
            MEM_SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

    // Load side: pick the lane and sign- or zero-extend it.
    always_comb begin
        ld_data = lane;
        case (size)
            MEM_SIZE_B: ld_data = is_unsigned ? {24'h0, lane[7:0]}
                                              : {{24{lane[7]}}, lane[7:0]};
            MEM_SIZE_H: ld_data = is_unsigned ? {16'h0, lane[15:0]}
                                              : {{16{lane[15]}}, lane[15:0]};
            default:    ld_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer. Accepts one decoded access per
// instruction, runs the req/gnt/rvalid data-bus handshake, stalls the
// pipeline until the access resolves and returns extended load data plus
// an exception code with a one-cycle done pulse.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int EXP_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_en,
    input  logic             flush,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_be,
    output logic [31:0]      bus_wdata,
    input  logic             bus_gnt,
    input  logic             bus_rvalid,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_err,
    output logic             stall_req,
    output logic             done,
    output logic [31:0]      ld_data,
    output logic [EXP_W-1:0] exp_code
);
    import mem_access_ctrl_pkg::*;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             discard;     // granted access flushed: finish on bus, report nothing
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             uns_q;
    logic [EXP_W-1:0] exc_q;
    logic [31:0]      ld_q;

    logic             in_idle;
    logic             accept;
    logic             timeout_hit;
    logic [1:0]       al_size;
    logic [1:0]       al_lo;
    logic             misaligned;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      ld_ext;
    logic [EXP_W-1:0] fault_code;

    assign in_idle     = (state == ST_IDLE);
    assign accept      = cpu_en & req_valid & ~flush;
    assign timeout_hit = (cnt == CNT_LAST);
    assign fault_code  = bus_we ? EXP_W'(ISA_EXP_ST_ACCESS_FAULT)
                                : EXP_W'(ISA_EXP_LD_ACCESS_FAULT);

    // The aligner sees the incoming request while idle (store steering,
    // alignment) and the latched access afterwards (load extraction).
    assign al_size = in_idle ? req_size     : size_q;
    assign al_lo   = in_idle ? req_addr[1:0] : lane_q;

    mem_access_ctrl_lsu_align u_lsu_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .is_unsigned (uns_q),
        .wdata       (req_wdata),
        .rdata       (bus_rdata),
        .misaligned  (misaligned),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .ld_data     (ld_ext)
    );

    assign stall_req = (in_idle & accept) | (state == ST_REQ) | (state == ST_WAIT);
    assign done      = (state == ST_DONE);
    assign ld_data   = ld_q;
    assign exp_code  = done ? exc_q : EXP_W'(ISA_EXP_NONE);

    // Access sequencer: state, timeout counter and all registered bus/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            size_q    <= MEM_SIZE_B;
            lane_q    <= '0;
            uns_q     <= 1'b0;
            exc_q     <= EXP_W'(ISA_EXP_NONE);
            ld_q      <= '0;
        end else if (cpu_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // branch below reads the pre-edge values of cnt, discard and bus_we.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        discard <= 1'b0;
                        ld_q    <= '0;
                        if (misaligned) begin
                            state <= ST_DONE;
                            exc_q <= req_we ? EXP_W'(ISA_EXP_ST_MISALIGNED)
                                            : EXP_W'(ISA_EXP_LD_MISALIGNED);
                        end else begin
                            state     <= ST_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= be;
                            bus_wdata <= wdata_rep;
                            size_q    <= req_size;
                            lane_q    <= req_addr[1:0];
                            uns_q     <= req_unsigned;
                            exc_q     <= EXP_W'(ISA_EXP_NONE);
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (flush && !bus_gnt) begin
                        // Nothing reached the bus yet: drop it silently.
                        state   <= ST_IDLE;
                        bus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        // Timeout wins over a same-cycle grant; its late
                        // response lands in IDLE/DONE and is ignored.
                        bus_req <= 1'b0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DONE;
                            exc_q <= fault_code;
                        end
                    end else if (bus_gnt) begin
                        state   <= ST_WAIT;
                        bus_req <= 1'b0;
                        discard <= flush;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus_rvalid || timeout_hit) begin
                        if (discard || flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DONE;
                            if (bus_rvalid && !bus_err) begin
                                ld_q <= bus_we ? 32'h0 : ld_ext;
                            end else begin
                                exc_q <= fault_code;
                            end
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a directed vector table with
// hand-derived expectations, hand-written freeze/reset sequences, and
// randomized accesses scored against a timeline-level reference model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int EXP_W   = 4;
    localparam int NEVER   = 99;
    localparam int RUN_CYC = TIMEOUT + 8;
    localparam int N_RAND  = 250;

    logic clk = 1'b0, rst_n = 1'b0, cpu_en = 1'b1, flush = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic bus_req, bus_we, bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0, ld_data;
    logic [3:0] bus_be;
    logic stall_req, done;
    logic [EXP_W-1:0] exp_code;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .flush(flush),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err), .stall_req(stall_req),
        .done(done), .ld_data(ld_data), .exp_code(exp_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we; logic [1:0] size; logic uns;
        logic [31:0] addr, wdata, rdata; logic err;
        int gnt_dly, rv_dly, flush_cyc;   // REQ cycles before gnt, WAIT cycles before rvalid
    } acc_t;

    typedef struct {
        int done_n, done_cyc, stall_n, req_n, exp_bad, unstable;
        logic [3:0] exp; logic [31:0] ld; logic [3:0] be;
        logic [31:0] wd, addr; logic we;
    } obs_t;

    typedef struct {
        acc_t a;
        int e_done; logic [3:0] e_exp; logic [31:0] e_ld;
        logic [3:0] e_be; logic [31:0] e_wd; int e_stall, e_req;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: derive the whole access outcome from event times.
    function automatic obs_t model(input acc_t a);
        obs_t e;
        int lo, nb, t_gnt, t_rv, t_end;
        bit rv_ok;
        logic [31:0] v, mask;
        e = '{default: 0};
        e.exp = ISA_EXP_NONE;
        lo = int'(a.addr[1:0]);
        nb = (a.size == 2'b00) ? 1 : (a.size == 2'b01) ? 2 : 4;
        if (a.flush_cyc == 0) return e;
        if ((lo % nb) != 0) begin
            e.done_n = 1; e.done_cyc = 1; e.stall_n = 1;
            e.exp = a.we ? ISA_EXP_ST_MISALIGNED : ISA_EXP_LD_MISALIGNED;
            return e;
        end
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= lo) && (i < lo + nb);
            e.wd[8*i +: 8] = a.wdata[8*(i % nb) +: 8];
        end
        e.addr = a.addr & ~32'h3;
        e.we = a.we;
        t_gnt = (a.gnt_dly < TIMEOUT) ? a.gnt_dly + 1 : NEVER;
        e.req_n = (a.gnt_dly < TIMEOUT) ? a.gnt_dly + 1 : TIMEOUT;
        t_rv = t_gnt + 1 + a.rv_dly;
        rv_ok = (t_rv <= TIMEOUT);
        t_end = rv_ok ? t_rv : TIMEOUT;
        if (a.flush_cyc < t_gnt && a.flush_cyc <= t_end) begin
            e.req_n = a.flush_cyc;
            e.stall_n = a.flush_cyc + 1;
            return e;
        end
        e.stall_n = t_end + 1;
        if (a.flush_cyc <= t_end) return e;
        e.done_n = 1;
        e.done_cyc = t_end + 1;
        if (rv_ok && !a.err) begin
            v = a.rdata >> (8 * lo);
            if (nb < 4) begin
                mask = (32'h1 << (8 * nb)) - 32'h1;
                v = v & mask;
                if (!a.uns && v[8*nb-1]) v = v | ~mask;
            end
            e.ld = a.we ? 32'h0 : v;
        end else begin
            e.exp = a.we ? ISA_EXP_ST_ACCESS_FAULT : ISA_EXP_LD_ACCESS_FAULT;
        end
        return e;
    endfunction

    // Present one access and play the bus slave for RUN_CYC cycles.
    // Called at posedge+1; returns at posedge+1.
    task automatic run(input acc_t a, output obs_t o);
        int req_seen, wait_seen;
        bit granted;
        o = '{default: 0};
        o.exp = ISA_EXP_NONE;
        req_valid = 1'b1; req_we = a.we; req_size = a.size; req_unsigned = a.uns;
        req_addr = a.addr; req_wdata = a.wdata;
        req_seen = 0; wait_seen = 0; granted = 1'b0;
        for (int c = 0; c < RUN_CYC; c++) begin
            flush      = (c == a.flush_cyc);
            bus_gnt    = bus_req && (req_seen == a.gnt_dly);
            bus_rvalid = granted && (wait_seen == a.rv_dly);
            bus_err    = bus_rvalid && a.err;
            bus_rdata  = bus_rvalid ? a.rdata : $urandom;
            @(negedge clk);
            if (stall_req) o.stall_n++;
            if (bus_req) begin
                if (o.req_n == 0) begin
                    o.be = bus_be; o.wd = bus_wdata; o.addr = bus_addr; o.we = bus_we;
                end else if (bus_be !== o.be || bus_wdata !== o.wd ||
                             bus_addr !== o.addr || bus_we !== o.we) begin
                    o.unstable++;
                end
                o.req_n++;
            end
            if (done) begin
                o.done_n++; o.done_cyc = c; o.exp = exp_code; o.ld = ld_data;
            end else if (exp_code !== ISA_EXP_NONE) begin
                o.exp_bad++;
            end
            if (granted) wait_seen++;
            if (bus_gnt) granted = 1'b1;
            if (bus_req) req_seen++;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".done_n"}, 32'(o.done_n), 32'(e.done_n));
        check({tag, ".stall_cycles"}, 32'(o.stall_n), 32'(e.stall_n));
        check({tag, ".req_cycles"}, 32'(o.req_n), 32'(e.req_n));
        check({tag, ".exp_when_idle"}, 32'(o.exp_bad), 32'd0);
        if (e.done_n != 0) begin
            check({tag, ".done_cycle"}, 32'(o.done_cyc), 32'(e.done_cyc));
            check({tag, ".exp_code"}, 32'(o.exp), 32'(e.exp));
            check({tag, ".ld_data"}, o.ld, e.ld);
        end
        if (e.req_n != 0) begin
            check({tag, ".bus_be"}, 32'(o.be), 32'(e.be));
            check({tag, ".bus_wdata"}, o.wd, e.wd);
            check({tag, ".bus_addr"}, o.addr, e.addr);
            check({tag, ".bus_we"}, 32'(o.we), 32'(e.we));
            check({tag, ".bus_stable"}, 32'(o.unstable), 32'd0);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, wdata, rdata, input logic err,
                                input int gd, rd, fc, e_done, input logic [3:0] e_exp,
                                input logic [31:0] e_ld, input logic [3:0] e_be,
                                input logic [31:0] e_wd, input int e_stall, e_req);
        vec_t v;
        v.a = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata, rdata: rdata,
                err: err, gnt_dly: gd, rv_dly: rd, flush_cyc: fc};
        v.e_done = e_done; v.e_exp = e_exp; v.e_ld = e_ld; v.e_be = e_be;
        v.e_wd = e_wd; v.e_stall = e_stall; v.e_req = e_req;
        return v;
    endfunction

    vec_t tbl[14];
    obs_t o, e;
    acc_t a;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we size uns addr      wdata        rdata        err gd     rd fc     | dn exp                      ld           be     wd           st  rq
        tbl[0]  = mk(0, 2'b10, 0, 32'h100,  32'h0,       32'hDEADBEEF, 0, 0,     0, NEVER, 1, ISA_EXP_NONE,            32'hDEADBEEF, 4'hF, 32'h0,       3,  1);
        tbl[1]  = mk(0, 2'b00, 0, 32'h103,  32'h0,       32'h80000000, 0, 0,     0, NEVER, 1, ISA_EXP_NONE,            32'hFFFFFF80, 4'h8, 32'h0,       3,  1);
        tbl[2]  = mk(0, 2'b00, 1, 32'h103,  32'h0,       32'h80000000, 0, 0,     0, NEVER, 1, ISA_EXP_NONE,            32'h00000080, 4'h8, 32'h0,       3,  1);
        tbl[3]  = mk(1, 2'b01, 0, 32'h1001, 32'h1234,    32'h0,        0, 0,     0, NEVER, 1, ISA_EXP_ST_MISALIGNED,   32'h0,        4'h0, 32'h0,       1,  0);
        tbl[4]  = mk(1, 2'b00, 0, 32'h2,    32'hAB,      32'h0,        0, 1,     2, NEVER, 1, ISA_EXP_NONE,            32'h0,        4'h4, 32'hABABABAB, 6, 2);
        tbl[5]  = mk(0, 2'b10, 0, 32'h40,   32'h0,       32'h0,        0, NEVER, 0, NEVER, 1, ISA_EXP_LD_ACCESS_FAULT, 32'h0,        4'hF, 32'h0,       17, 16);
        tbl[6]  = mk(0, 2'b10, 0, 32'h80,   32'h0,       32'h12345678, 0, 0,     2, 2,     0, ISA_EXP_NONE,            32'h0,        4'hF, 32'h0,       5,  1);
        tbl[7]  = mk(0, 2'b10, 0, 32'h84,   32'h0,       32'h1,        1, 0,     0, NEVER, 1, ISA_EXP_LD_ACCESS_FAULT, 32'h0,        4'hF, 32'h0,       3,  1);
        tbl[8]  = mk(0, 2'b01, 0, 32'h2,    32'h0,       32'h80010000, 0, 0,     0, NEVER, 1, ISA_EXP_NONE,            32'hFFFF8001, 4'hC, 32'h0,       3,  1);
        tbl[9]  = mk(1, 2'b10, 0, 32'h10,   32'h12345678, 32'h0,       0, 2,     0, 1,     0, ISA_EXP_NONE,            32'h0,        4'hF, 32'h12345678, 2, 1);
        tbl[10] = mk(0, 2'b10, 0, 32'h6,    32'h0,       32'h0,        0, 0,     0, NEVER, 1, ISA_EXP_LD_MISALIGNED,   32'h0,        4'h0, 32'h0,       1,  0);
        tbl[11] = mk(0, 2'b11, 1, 32'h8,    32'h0,       32'h87654321, 0, 0,     1, NEVER, 1, ISA_EXP_NONE,            32'h87654321, 4'hF, 32'h0,       4,  1);
        tbl[12] = mk(1, 2'b01, 0, 32'h2,    32'hBEEF5A5A, 32'h0,       0, 0,     0, NEVER, 1, ISA_EXP_NONE,            32'h0,        4'hC, 32'h5A5A5A5A, 3, 1);
        tbl[13] = mk(1, 2'b10, 0, 32'h20,   32'h0,       32'h0,        1, 0,     0, NEVER, 1, ISA_EXP_ST_ACCESS_FAULT, 32'h0,        4'hF, 32'h0,       3,  1);

        // Reset state.
        #12;
        check("reset.bus_req", 32'(bus_req), 32'd0);
        check("reset.stall_req", 32'(stall_req), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.exp_code", 32'(exp_code), 32'(ISA_EXP_NONE));
        check("reset.bus_addr", bus_addr, 32'h0);
        check("reset.bus_be", 32'(bus_be), 32'h0);
        check("reset.ld_data", ld_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            e = '{default: 0};
            e.done_n = tbl[i].e_done; e.done_cyc = tbl[i].e_stall;
            e.stall_n = tbl[i].e_stall; e.req_n = tbl[i].e_req;
            e.exp = tbl[i].e_exp; e.ld = tbl[i].e_ld; e.be = tbl[i].e_be;
            e.wd = tbl[i].e_wd; e.addr = tbl[i].a.addr & ~32'h3; e.we = tbl[i].a.we;
            run(tbl[i].a, o);
            compare($sformatf("tbl%0d", i), o, e);
        end

        // cpu_en=0 freezes REQ and WAIT; handshakes are ignored while frozen.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h200; req_wdata = '0;
        @(negedge clk); check("frz.accept_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1; req_valid = 1'b0;
        cpu_en = 1'b0; bus_gnt = 1'b1;
        repeat (TIMEOUT + 2) @(posedge clk);
        #1;
        @(negedge clk);
        check("frz.req_held", 32'(bus_req), 32'd1);
        check("frz.req_stall", 32'(stall_req), 32'd1);
        cpu_en = 1'b1;
        @(posedge clk); #1; bus_gnt = 1'b0;
        @(negedge clk); check("frz.req_dropped", 32'(bus_req), 32'd0);
        cpu_en = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("frz.wait_no_done", 32'(done), 32'd0);
        check("frz.wait_stall", 32'(stall_req), 32'd1);
        bus_rdata = 32'hCAFEF00D; cpu_en = 1'b1;
        @(posedge clk); #1; bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("frz.done", 32'(done), 32'd1);
        check("frz.ld_data", ld_data, 32'hCAFEF00D);
        check("frz.exp_code", 32'(exp_code), 32'(ISA_EXP_NONE));
        check("frz.done_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("frz.done_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in REQ drops bus_req without a clock edge.
        req_valid = 1'b1; req_addr = 32'h300;
        @(posedge clk); #1; req_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        check("arst.bus_req", 32'(bus_req), 32'd0);
        check("arst.stall_req", 32'(stall_req), 32'd0);
        check("arst.bus_addr", bus_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        a = '{we: 1'b0, size: 2'b10, uns: 1'b0, addr: 32'h304, wdata: 32'h0,
              rdata: 32'h0BADF00D, err: 1'b0, gnt_dly: 1, rv_dly: 0, flush_cyc: NEVER};
        run(a, o);
        compare("arst.recover", o, model(a));

        // Randomized accesses against the reference model.
        for (int i = 0; i < N_RAND; i++) begin
            a.we = 1'($urandom_range(0, 1));
            a.size = 2'($urandom_range(0, 3));
            a.uns = 1'($urandom_range(0, 1));
            a.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (a.size == 2'b01) a.addr[0] = 1'b0;
                else if (a.size != 2'b00) a.addr[1:0] = 2'b00;
            end
            a.wdata = $urandom;
            a.rdata = $urandom;
            a.err = ($urandom_range(0, 7) == 0);
            a.gnt_dly = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TIMEOUT + 1);
            a.rv_dly = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
            a.flush_cyc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT + 2) : NEVER;
            run(a, o);
            compare($sformatf("rnd%0d", i), o, model(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
